pio_shift_out: RTL and testbench

//  Serialises the 8-bit parallel output of the Avalon output PIO onto an external 74HC595-style

---
 rtl/pio_shift_out.sv | 169 ++++++++++++++++
 tb/tb_pio_shift_out.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_shift_out.sv
// -----------------------------------------------------------------------------
// pio_shift_out
// Serialises the parallel value coming out of the Avalon output PIO onto an
// external 74HC595-style shift/latch register. A transfer is started whenever
// the PIO value differs from the last value latched into the external part, or
// when a refresh is requested. Changes seen while a transfer is running are not
// captured; only the value present at the next idle cycle is considered.
//
// Ports
//   clk        in   1       system clock
//   reset_n    in   1       asynchronous, active-low reset
//   i_data_in  in   DATA_W  parallel value from the PIO out_port
//   i_refresh  in   1       one-cycle pulse forcing a retransfer of i_data_in
//   o_sclk     out  1       shift clock (external part samples on rising edge)
//   o_sdo      out  1       serial data
//   o_rclk     out  1       storage-latch strobe, active high
//   o_busy     out  1       high while a transfer is in progress
// -----------------------------------------------------------------------------
module pio_shift_out #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] i_data_in,
   input  logic              i_refresh,
   output logic              o_sclk,
   output logic              o_sdo,
   output logic              o_rclk,
   output logic              o_busy
);

   // Counter widths are kept at least one bit so CLK_DIV=1 still elaborates.
   localparam int BIT_W = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_shift;      // bits still to be presented, next bit at the head
   logic [DATA_W-1:0]   r_data;       // value captured at transfer start
   logic [DATA_W-1:0]   r_last_sent;  // value held by the external latch
   logic                r_pending;    // sticky retransfer request
   logic [BIT_W-1:0]    r_bit_cnt;
   logic [DIV_W-1:0]    r_div_cnt;
   logic                r_sclk;
   logic                r_sdo;
   logic                r_rclk;
   logic                r_busy;

   logic                w_start;
   logic                w_div_last;
   logic [DATA_W-1:0]   w_shift_nxt;

   // Bit that leads the serial stream for a given word.
   function automatic logic head_bit(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
   endfunction

   // Drop the bit just sent so the following bit becomes the head.
   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
   endfunction

   assign w_start     = (i_data_in != r_last_sent) || r_pending || i_refresh;
   assign w_div_last  = (r_div_cnt == DIV_LAST);
   assign w_shift_nxt = advance(r_shift);

   // Transfer sequencer: IDLE -> SHIFT -> LATCH -> IDLE, all pins registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_shift     <= {DATA_W{1'b0}};
         r_data      <= {DATA_W{1'b0}};
         r_last_sent <= {DATA_W{1'b0}};
         r_pending   <= 1'b1;   // forces a full transfer after reset release
         r_bit_cnt   <= BIT_ZERO;
         r_div_cnt   <= DIV_ZERO;
         r_sclk      <= 1'b0;
         r_sdo       <= 1'b0;
         r_rclk      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  // A refresh coincident with the start is absorbed here.
                  r_shift   <= i_data_in;
                  r_data    <= i_data_in;
                  r_pending <= 1'b0;
                  r_bit_cnt <= BIT_ZERO;
                  r_div_cnt <= DIV_ZERO;
                  r_sdo     <= head_bit(i_data_in);
                  r_busy    <= 1'b1;
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (i_refresh) begin
                  r_pending <= 1'b1;
               end
               if (w_div_last) begin
                  r_div_cnt <= DIV_ZERO;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                  end else begin
                     // Falling sclk: present the next bit, or finish after the last.
                     r_sclk <= 1'b0;
                     if (r_bit_cnt == BIT_LAST) begin
                        r_rclk  <= 1'b1;
                        r_state <= ST_LATCH;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_ONE;
                        r_shift   <= w_shift_nxt;
                        r_sdo     <= head_bit(w_shift_nxt);
                     end
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + DIV_ONE;
               end
            end
            ST_LATCH: begin
               if (i_refresh) begin
                  r_pending <= 1'b1;
               end
               if (w_div_last) begin
                  r_div_cnt   <= DIV_ZERO;
                  r_rclk      <= 1'b0;
                  r_busy      <= 1'b0;
                  r_sdo       <= 1'b0;
                  r_last_sent <= r_data;
                  r_state     <= ST_IDLE;
               end else begin
                  r_div_cnt <= r_div_cnt + DIV_ONE;
               end
            end
            default: begin
               // Unreachable encoding: park safely with the pins inactive.
               r_state   <= ST_IDLE;
               r_div_cnt <= DIV_ZERO;
               r_bit_cnt <= BIT_ZERO;
               r_sclk    <= 1'b0;
               r_sdo     <= 1'b0;
               r_rclk    <= 1'b0;
               r_busy    <= 1'b0;
               r_pending <= 1'b1;
            end
         endcase
      end
   end

   assign o_sclk = r_sclk;
   assign o_sdo  = r_sdo;
   assign o_rclk = r_rclk;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_pio_shift_out.sv
// -----------------------------------------------------------------------------
// Testbench for pio_shift_out. Two instances share one stimulus stream:
//   inst0: CLK_DIV=4, MSB_FIRST=1   inst1: CLK_DIV=1, MSB_FIRST=0
// A reference model decides, per clock, which values must end up in the
// external latch and pushes them into a queue; a monitor models the external
// 74HC595 (shift on sclk rise, latch on rclk rise) and pops/compares.
// -----------------------------------------------------------------------------
module tb_pio_shift_out;

   localparam int DATA_W = 8;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        refresh = 1'b0;

   logic [1:0]  sclk_w;
   logic [1:0]  sdo_w;
   logic [1:0]  rclk_w;
   logic [1:0]  busy_w;
   logic [1:0]  quiet_w;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input int g, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s inst%0d: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, g, act, act, exp, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int CD = (g == 0) ? 4 : 1;
      localparam int MF = (g == 0) ? 1 : 0;
      localparam int T  = (2 * DATA_W + 1) * CD;

      pio_shift_out #(.DATA_W(DATA_W), .CLK_DIV(CD), .MSB_FIRST(MF)) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .i_data_in (data_in),
         .i_refresh (refresh),
         .o_sclk    (sclk_w[g]),
         .o_sdo     (sdo_w[g]),
         .o_rclk    (rclk_w[g]),
         .o_busy    (busy_w[g])
      );

      // ---------------- reference model ----------------
      logic [7:0] exp_q[$];
      int         busy_left = 0;
      bit         pending   = 1'b1;
      logic [7:0] last      = 8'h00;
      int         n_push    = 0;
      int         n_pop     = 0;

      assign quiet_w[g] = (busy_left == 0) && (n_push == n_pop);

      // Transfer-level model: an idle clock starts a T-cycle transfer when
      // the value changed, a refresh is pending, or a refresh arrives now.
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            if (busy_left != 0) begin
               void'(exp_q.pop_back());
               n_push <= n_push - 1;
            end
            busy_left <= 0;
            pending   <= 1'b1;
            last      <= 8'h00;
         end else if (busy_left == 0) begin
            if ((data_in != last) || pending || refresh) begin
               exp_q.push_back(data_in);
               n_push    <= n_push + 1;
               last      <= data_in;
               pending   <= 1'b0;
               busy_left <= T;
            end
         end else begin
            if (refresh) pending <= 1'b1;
            busy_left <= busy_left - 1;
         end
      end

      // ---------------- monitor / external register model ----------------
      bit         p_sclk = 1'b0, p_rclk = 1'b0, p_busy = 1'b0;
      int         rises = 0, hi_run = 0, rclk_run = 0, busy_run = 0;
      logic [7:0] ext_sr = 8'h00;
      logic [7:0] expv;

      always @(negedge clk) begin
         chk(busy_w[g] == (busy_left != 0), "busy_vs_model", g, int'(busy_w[g]), int'(busy_left != 0));
         if (!reset_n) begin
            p_sclk <= 1'b0; p_rclk <= 1'b0; p_busy <= 1'b0;
            rises <= 0; hi_run <= 0; rclk_run <= 0; busy_run <= 0;
         end else begin
            if (sclk_w[g] && !p_sclk) begin
               ext_sr <= (MF != 0) ? {ext_sr[6:0], sdo_w[g]} : {sdo_w[g], ext_sr[7:1]};
               rises  <= rises + 1;
            end
            hi_run <= sclk_w[g] ? hi_run + 1 : 0;
            if (!sclk_w[g] && p_sclk) chk(hi_run == CD, "sclk_high_len", g, hi_run, CD);

            if (rclk_w[g] && !p_rclk) begin
               chk(rises == DATA_W, "sclk_rises_per_latch", g, rises, DATA_W);
               chk(sclk_w[g] == 1'b0, "sclk_low_in_latch", g, int'(sclk_w[g]), 0);
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_latch", g, int'(ext_sr), -1);
               end else begin
                  expv = exp_q.pop_front();
                  chk(ext_sr == expv, "latched_value", g, int'(ext_sr), int'(expv));
               end
               n_pop <= n_pop + 1;
               rises <= 0;
            end
            rclk_run <= rclk_w[g] ? rclk_run + 1 : 0;
            if (!rclk_w[g] && p_rclk) chk(rclk_run == CD, "rclk_high_len", g, rclk_run, CD);

            busy_run <= busy_w[g] ? busy_run + 1 : 0;
            if (!busy_w[g] && p_busy) chk(busy_run == T, "busy_len", g, busy_run, T);

            p_sclk <= sclk_w[g];
            p_rclk <= rclk_w[g];
            p_busy <= busy_w[g];
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      int stable = 0;
      step(2);
      while (stable < 3 && n < 3000) begin
         if (quiet_w == 2'b11 && busy_w == 2'b00) stable++;
         else stable = 0;
         step(1);
         n++;
      end
      chk(n < 3000, "idle_timeout", -1, n, 3000);
   endtask

   task automatic wait_busy0();
      int n = 0;
      while (!busy_w[0] && n < 200) begin
         step(1);
         n++;
      end
      chk(n < 200, "busy_start_timeout", 0, n, 200);
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      step(1);
      refresh = 1'b0;
   endtask

   initial begin
      logic [7:0] prev;
      int r;

      // 1: reset, then release with data 0x00 -> one transfer of 0x00
      step(3);
      chk({sclk_w, sdo_w, rclk_w, busy_w} == 8'h00, "reset_outputs", -1,
          int'({sclk_w, sdo_w, rclk_w, busy_w}), 0);
      reset_n = 1'b1;
      wait_idle();

      // 2: single change
      data_in = 8'hA5;
      wait_idle();

      // 3: two changes while busy -> only the latest is sent
      data_in = 8'h5A;
      wait_busy0();
      step(10); data_in = 8'h11;
      step(10); data_in = 8'h33;
      wait_idle();

      // 4: change and return while busy -> no second transfer
      data_in = 8'h3C;
      wait_busy0();
      step(5); data_in = 8'hA5;
      step(5); data_in = 8'h3C;
      wait_idle();
      step(20);

      // 5: refresh in idle, then three refreshes during one transfer
      pulse_refresh();
      wait_idle();
      pulse_refresh();
      wait_busy0();
      pulse_refresh(); step(3);
      pulse_refresh(); step(3);
      pulse_refresh();
      wait_idle();

      // 6: reset after the third sclk rise of inst0 -> pins drop at once, full resend
      data_in = 8'hC3;
      wait_busy0();
      step(21);
      reset_n = 1'b0;
      #1;
      chk({sclk_w, sdo_w, rclk_w, busy_w} == 8'h00, "midreset_outputs", -1,
          int'({sclk_w, sdo_w, rclk_w, busy_w}), 0);
      step(2);
      reset_n = 1'b1;
      wait_idle();

      // 7: single low bit with LSB-first on inst1 exercised explicitly
      data_in = 8'h01;
      wait_idle();

      // Randomised phase: value changes (sometimes back to a recent value) and refreshes
      prev = data_in;
      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4) begin
            if ($urandom_range(0, 3) == 0) data_in = prev;
            else begin
               prev    = data_in;
               data_in = 8'($urandom);
            end
         end else if (r == 9) begin
            pulse_refresh();
         end
         step(int'($urandom_range(1, 40)));
      end
      refresh = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
